uart_rx_core: RTL and testbench

- Parametrised single-clock UART receive engine; next generation of the team's fixed 8N1 receiver.
- Adds configurable data width, oversample ratio, optional parity, one or two stop bits, false-start rejection, error flags, break detect, and a valid/ready output handshake.
- Sits in the clk_rf domain between the rx pin and the receive FIFO write port, or any stream consumer.

---
 rtl/uart_rx_core.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// Parametrised oversampling UART receive engine with parity/stop checks and valid/ready output.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by a 2-of-3 vote around mid-bit.
module uart_rx_core #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk_rf,
  input  logic                 rst_rf_n,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_VOTE_EN
  // The vote ends one cycle past the nominal point; later bits keep an OVERSAMPLE period.
  localparam logic [CntW-1:0] StartDec = CntW'(OVERSAMPLE / 2);
`else
  localparam logic [CntW-1:0] StartDec = CntW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [CntW-1:0] BitDec   = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] LastData = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic                 rx_meta_q, rx_s_q;
  logic                 sample_bit;
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_q, ferr_d;
  logic                 frame_done;
  logic                 perr_w, brk_w;

  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 break_det_q, break_det_d;
  logic                 overrun_q, overrun_d;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] rx_h_q;
  assign sample_bit = (rx_h_q[1] & rx_h_q[0]) | (rx_h_q[1] & rx_s_q) | (rx_h_q[0] & rx_s_q);
`else
  assign sample_bit = rx_s_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    par_bit_d  = par_bit_q;
    ferr_d     = ferr_q;
    frame_done = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        ferr_d    = 1'b0;
        par_bit_d = 1'b0;
        if (!rx_s_q) begin
          state_d   = StStart;
          par_en_d  = parity_en;
          par_odd_d = parity_odd;
        end
      end
      StStart: begin
        if (cnt_q == StartDec) begin
          cnt_d   = '0;
          state_d = sample_bit ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitDec) begin
          cnt_d   = '0;
          shift_d = {sample_bit, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LastData) begin
            bit_idx_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (cnt_q == BitDec) begin
          cnt_d     = '0;
          par_bit_d = sample_bit;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (cnt_q == BitDec) begin
          cnt_d = '0;
          if (!sample_bit) ferr_d = 1'b1;
          if (bit_idx_q == LastStop) begin
            bit_idx_d  = '0;
            frame_done = 1'b1;
            state_d    = StIdle;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign perr_w = par_en_q & (^{shift_q, par_bit_q, par_odd_q});
  assign brk_w  = ferr_d & ~(|shift_q) & ~(par_en_q & par_bit_q);

  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;
    overrun_d    = 1'b0;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_valid_d   = 1'b1;
        rx_data_d    = shift_q;
        parity_err_d = perr_w;
        frame_err_d  = ferr_d;
        break_det_d  = brk_w;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_rf or negedge rst_rf_n) begin
    if (!rst_rf_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
      rx_h_q       <= 2'b11;
`endif
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_bit_q    <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
      rx_h_q       <= {rx_h_q[0], rx_s_q};
`endif
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      par_bit_q    <= par_bit_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frame table, handshake/reset/stop-bit sequences, random frames.
// Expected latency accounts for UART_RX_MAJORITY_VOTE_EN when defined.
module tb_uart_rx_core;
  localparam int OS = 16;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VoteLat = 1;
`else
  localparam int VoteLat = 0;
`endif
  // Start edge to visible rx_valid: 2 sync + idle detect + half start bit + data + stop.
  localparam int Lat8N1 = 2 + 1 + OS / 2 + 8 * OS + OS + VoteLat;
  localparam int Lat8P1 = Lat8N1 + OS;

  logic clk = 1'b0;
  logic rst_n, rx, rx2, parity_en, parity_odd, ready, ready2, sel2;
  logic [7:0] rx_data, data2;
  logic rx_valid, parity_err, frame_err, break_det, overrun;
  logic valid2, perr2, ferr2, brk2, ovr2;

  always #5 clk = ~clk;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) dut (
    .clk_rf(clk), .rst_rf_n(rst_n), .rx(rx), .parity_en(parity_en), .parity_odd(parity_odd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(ready), .parity_err(parity_err),
    .frame_err(frame_err), .break_det(break_det), .overrun(overrun)
  );

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(2)) dut2 (
    .clk_rf(clk), .rst_rf_n(rst_n), .rx(rx2), .parity_en(1'b0), .parity_odd(1'b0),
    .rx_data(data2), .rx_valid(valid2), .rx_ready(ready2), .parity_err(perr2),
    .frame_err(ferr2), .break_det(brk2), .overrun(ovr2)
  );

  typedef struct {
    logic [7:0] data;
    logic perr;
    logic ferr;
    logic brk;
    int   cyc;
  } obs_t;

  typedef struct {
    logic [7:0] data;
    logic pen, podd, pbit, stop;
    logic [7:0] exp_data;
    logic exp_perr, exp_ferr, exp_brk;
    int   lat;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   ovr_cnt = 0;
  obs_t obs_q[$];
  obs_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Collect every accepted word and count overrun pulses.
  always @(negedge clk) begin
    #2;
    if (rx_valid && ready) obs_q.push_back('{rx_data, parity_err, frame_err, break_det, cyc});
    if (overrun) ovr_cnt++;
  end

  task automatic check(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    if (sel2) rx2 = b;
    else rx = b;
    repeat (OS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx  = 1'b1;
    rx2 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                            input logic pbit, input logic s1, input logic s2);
    parity_en  = pen;
    parity_odd = podd;
    start_cyc  = cyc;
    drive_bit(1'b0);
    // Mid-frame changes must be ignored until the next start.
    parity_en  = 1'($urandom);
    parity_odd = 1'($urandom);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(s1);
    if (sel2) drive_bit(s2);
  endtask

  task automatic expect_word(input string name, input logic [7:0] d, input logic pe,
                             input logic fe, input logic bk, input int lat);
    obs_t o;
    int   n = 0;
    while (obs_q.size() == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (obs_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: no word received, expected %02h", name, d);
    end else begin
      o = obs_q.pop_front();
      check(name, {o.perr, o.ferr, o.brk, o.data}, {pe, fe, bk, d});
      if (lat >= 0) check({name, "_latency"}, o.cyc - start_cyc, lat);
    end
  endtask

  vec_t tbl[6];
  obs_t e, o;
  logic [7:0] d;
  logic pen, podd, pbit, stp;
  int ones, gap, ov0;

  initial begin
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, Lat8N1};
    tbl[1] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, Lat8P1};
    tbl[2] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, Lat8P1};
    tbl[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, Lat8N1};
    tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, Lat8P1};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, Lat8P1};

    rx = 1'b1; rx2 = 1'b1; rst_n = 1'b0; ready = 1'b1; ready2 = 1'b0;
    parity_en = 1'b0; parity_odd = 1'b0; sel2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {rx_valid, rx_data, parity_err, frame_err, break_det, overrun}, 0);
    rst_n = 1'b1;
    idle(4);

    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].pen, tbl[i].podd, tbl[i].pbit, tbl[i].stop, 1'b1);
      expect_word($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_perr, tbl[i].exp_ferr,
                  tbl[i].exp_brk, tbl[i].lat);
      idle(2 * OS);
    end

    // Short low glitch is rejected, the next frame is unaffected.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(12);
    check("false_start_no_word", obs_q.size(), 0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_word("after_false_start", 8'h3C, 1'b0, 1'b0, 1'b0, Lat8N1);
    idle(2 * OS);

    // Stalled consumer: second frame is dropped with an overrun pulse.
    ready = 1'b0;
    ov0 = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("stall_first_held", {rx_valid, rx_data}, {1'b1, 8'h11});
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    check("overrun_pulse_count", ovr_cnt - ov0, 1);
    check("held_after_overrun", {rx_valid, rx_data, frame_err}, {1'b1, 8'h11, 1'b0});
    check("no_xfer_while_stalled", obs_q.size(), 0);
    ready = 1'b1;
    expect_word("stalled_word", 8'h11, 1'b0, 1'b0, 1'b0, -1);
    idle(200);
    check("no_spurious_word", obs_q.size(), 0);
    check("valid_cleared", rx_valid, 0);

    // Reset in the middle of the data bits of 0x5A.
    parity_en = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("reset_mid_frame", {rx_valid, rx_data, parity_err, frame_err, break_det, overrun}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    check("no_partial_word", obs_q.size(), 0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_word("after_reset", 8'h5A, 1'b0, 1'b0, 1'b0, Lat8N1);
    idle(2 * OS);

    // Two stop bits on the second instance, held with ready low.
    sel2 = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("stop2_ok", {valid2, perr2, ferr2, brk2, data2}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h5A});
    ready2 = 1'b1; @(negedge clk); ready2 = 1'b0; @(negedge clk);
    check("stop2_consumed", valid2, 0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2 * OS);
    check("stop2_second_low", {valid2, ferr2, brk2, data2}, {1'b1, 1'b1, 1'b0, 8'h5A});
    ready2 = 1'b1; @(negedge clk); ready2 = 1'b0;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2 * OS);
    check("stop2_break", {valid2, ferr2, brk2, data2}, {1'b1, 1'b1, 1'b1, 8'h00});
    check("stop2_no_overrun", ovr2, 0);
    ready2 = 1'b1; @(negedge clk); ready2 = 1'b0;
    sel2 = 1'b0;
    idle(OS);

    // Random frames against a word-level model.
    ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      pen  = 1'($urandom);
      podd = 1'($urandom);
      pbit = 1'($urandom);
      stp  = ($urandom_range(0, 7) != 0);
      ones = $countones(d);
      e.data = d;
      e.perr = pen && (((ones + int'(pbit)) % 2) != int'(podd));
      e.ferr = !stp;
      e.brk  = !stp && (d == 8'h00) && !(pen && pbit);
      e.cyc  = cyc + (pen ? Lat8P1 : Lat8N1);
      exp_q.push_back(e);
      send_frame(d, pen, podd, pbit, stp, 1'b1);
      gap = $urandom_range(0, 20);
      if (!stp) gap += OS;
      idle(gap);
    end
    idle(300);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rand_missing: no word, expected %02h", e.data);
      end else begin
        o = obs_q.pop_front();
        check("rand_word", {o.perr, o.ferr, o.brk, o.data}, {e.perr, e.ferr, e.brk, e.data});
        check("rand_latency", o.cyc, e.cyc);
      end
    end
    check("rand_extra_words", obs_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
